spi_reg_seq: RTL and testbench

SPI_REG_SEQ -- requirements
Module: spi_reg_seq

---
 rtl/spi_ctrl_pkg.sv | 25 ++
 rtl/spi_reg_seq.sv | 178 +++++++++++++++++
 tb/tb_spi_reg_seq.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI register sequencer: state encoding,
// instruction field widths and per-byte timing of the byte engine.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INSTR_HI = 3'd1,
        INSTR_LO = 3'd2,
        DATA     = 3'd3,
        DONE     = 3'd4
    } spiState_e;

    localparam int RW_W        = 1;
    localparam int LEN_W       = 2;
    localparam int ADDR_W      = 13;
    localparam int BYTE_CYCLES = 18;
    localparam int WDT_W       = 16;
    localparam int CNT_W       = 4;

    // Byte idx of a 32-bit word, byte 0 being the least significant.
    function automatic logic [7:0] selectByte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/spi_reg_seq.sv
// Register-access sequencer: turns a host read/write request into a stream of
// instruction and data bytes for an external SPI byte engine.
module spi_reg_seq
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned WDT_CYCLES = 1023
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_i,
    input  logic              rw_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic              ack_o,
    output logic              err_o,
    output logic [31:0]       rdata_o,
    output logic [7:0]        chunk_data_o,
    output logic              chunk_read_o,
    output logic              chunk_start_o,
    input  logic [7:0]        chunk_data_i,
    input  logic              chunk_busy_i,
    input  logic              chunk_finish_i
);

    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    spiState_e         state_q, state_d;
    logic [RW_W-1:0]   rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [7:0]        chunkData_q, chunkData_d;
    logic              chunkRead_q, chunkRead_d;
    logic              chunkStart_q, chunkStart_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  byteCnt_q, byteCnt_d;
    logic [WDT_W-1:0]  wdt_q, wdt_d;

    logic              byteState;
    logic              expire;
    logic [CNT_W-1:0]  nextCnt;
    logic [CNT_W-1:0]  lastCnt;

    assign byteState = (state_q == INSTR_HI) || (state_q == INSTR_LO) || (state_q == DATA);
    // A finish in the expiry cycle takes priority over the abort.
    assign expire    = byteState && !chunk_finish_i && (wdt_q == WDT_LAST);
    assign nextCnt   = byteCnt_q + CNT_W'(1);
    assign lastCnt   = CNT_W'(len_q) + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        len_d        = len_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        chunkData_d  = chunkData_q;
        chunkRead_d  = chunkRead_q;
        chunkStart_d = 1'b0;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        byteCnt_d    = byteCnt_q;
        wdt_d        = wdt_q;

        case (state_q)
            IDLE: begin
                wdt_d = '0;
                if (req_i && !chunk_busy_i) begin
                    rw_d         = rw_i;
                    addr_d       = addr_i;
                    len_d        = len_i;
                    wdata_d      = wdata_i;
                    rdata_d      = '0;
                    byteCnt_d    = '0;
                    chunkStart_d = 1'b1;
                    chunkData_d  = {rw_i, len_i, addr_i[ADDR_W-1:8]};
                    chunkRead_d  = 1'b0;
                    state_d      = INSTR_HI;
                end
            end
            INSTR_HI: begin
                if (chunk_finish_i) begin
                    chunkStart_d = 1'b1;
                    chunkData_d  = addr_q[7:0];
                    chunkRead_d  = 1'b0;
                    state_d      = INSTR_LO;
                end
            end
            INSTR_LO: begin
                if (chunk_finish_i) begin
                    chunkStart_d = 1'b1;
                    chunkData_d  = selectByte(wdata_q, len_q);
                    chunkRead_d  = rw_q[0];
                    byteCnt_d    = '0;
                    state_d      = DATA;
                end
            end
            DATA: begin
                if (chunk_finish_i) begin
                    if (rw_q[0]) begin
                        rdata_d = {rdata_q[23:0], chunk_data_i};
                    end
                    byteCnt_d = nextCnt;
                    if (nextCnt == lastCnt) begin
                        ack_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        chunkStart_d = 1'b1;
                        chunkData_d  = selectByte(wdata_q, len_q - nextCnt[LEN_W-1:0]);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The watchdog restarts with every new byte and runs only while one is in flight.
        if (byteState) begin
            wdt_d = chunk_finish_i ? '0 : wdt_q + WDT_W'(1);
        end
        if (expire) begin
            err_d        = 1'b1;
            ack_d        = 1'b0;
            chunkStart_d = 1'b0;
            wdt_d        = '0;
            state_d      = IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            rw_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            chunkData_q  <= '0;
            chunkRead_q  <= 1'b0;
            chunkStart_q <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            byteCnt_q    <= '0;
            wdt_q        <= '0;
        end else begin
            state_q      <= state_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            chunkData_q  <= chunkData_d;
            chunkRead_q  <= chunkRead_d;
            chunkStart_q <= chunkStart_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            byteCnt_q    <= byteCnt_d;
            wdt_q        <= wdt_d;
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign ack_o         = ack_q;
    assign err_o         = err_q;
    assign rdata_o       = rdata_q;
    assign chunk_data_o  = chunkData_q;
    assign chunk_read_o  = chunkRead_q;
    assign chunk_start_o = chunkStart_q;

endmodule

// File: tb/tb_spi_reg_seq.sv
// Self-checking bench for spi_reg_seq: a behavioural byte engine answers each
// start pulse, and every transaction is compared against a byte-level model.
module tb_spi_reg_seq;

    localparam int WDT = 20;

    logic        CLK;
    logic        RST;
    logic        req_i;
    logic        rw_i;
    logic [12:0] addr_i;
    logic [1:0]  len_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        ack_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic [7:0]  chunk_data_o;
    logic        chunk_read_o;
    logic        chunk_start_o;
    logic [7:0]  chunk_data_i;
    logic        chunk_busy_i;
    logic        chunk_finish_i;

    int errors = 0;
    int checks = 0;
    int cycCnt = 0;

    int         engDelay = spi_ctrl_pkg::BYTE_CYCLES - 1;
    logic [7:0] slaveQ[$];
    logic [7:0] logData[$];
    logic       logRead[$];
    int         logStart[$];
    int         stableErr = 0;
    int         engCnt = 0;
    bit         engBusy = 0;
    logic [7:0] curData;
    logic       curRead;

    spi_reg_seq #(.WDT_CYCLES(WDT)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .req_i         (req_i),
        .rw_i          (rw_i),
        .addr_i        (addr_i),
        .len_i         (len_i),
        .wdata_i       (wdata_i),
        .busy_o        (busy_o),
        .ack_o         (ack_o),
        .err_o         (err_o),
        .rdata_o       (rdata_o),
        .chunk_data_o  (chunk_data_o),
        .chunk_read_o  (chunk_read_o),
        .chunk_start_o (chunk_start_o),
        .chunk_data_i  (chunk_data_i),
        .chunk_busy_i  (chunk_busy_i),
        .chunk_finish_i(chunk_finish_i)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        forever begin
            @(posedge CLK);
            cycCnt = cycCnt + 1;
        end
    end

    // Byte engine: finishes engDelay cycles after each start pulse, logs what was sent.
    initial begin
        chunk_busy_i   = 1'b0;
        chunk_finish_i = 1'b0;
        chunk_data_i   = 8'h00;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                engBusy        = 0;
                engCnt         = 0;
                chunk_busy_i   = 1'b0;
                chunk_finish_i = 1'b0;
            end else if (chunk_start_o) begin
                engBusy        = 1;
                engCnt         = 0;
                chunk_busy_i   = 1'b1;
                chunk_finish_i = 1'b0;
                curData        = chunk_data_o;
                curRead        = chunk_read_o;
                logData.push_back(chunk_data_o);
                logRead.push_back(chunk_read_o);
                logStart.push_back(cycCnt);
                chunk_data_i = (slaveQ.size() > 0) ? slaveQ.pop_front() : 8'h00;
            end else if (engBusy) begin
                engCnt = engCnt + 1;
                if (chunk_data_o !== curData || chunk_read_o !== curRead) stableErr++;
                chunk_finish_i = (engCnt == engDelay);
                if (engCnt > engDelay) begin
                    engBusy        = 0;
                    chunk_busy_i   = 1'b0;
                    chunk_finish_i = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one full transaction from the current negedge and checks it against the model.
    task automatic applyStimulus(input string name, input logic rwV, input logic [12:0] addrV,
                                 input logic [1:0] lenV, input logic [31:0] wdataV);
        int         n, b, c0, ackCyc, errSeen;
        logic [7:0] expB[$];
        logic [31:0] expR, rdAtAck;
        logic [7:0] sb;
        n = int'(lenV) + 1;
        b = n + 2;
        expB.push_back(8'(int'(rwV) * 128 + int'(lenV) * 32 + int'(addrV) / 256));
        expB.push_back(8'(int'(addrV) % 256));
        for (int i = n - 1; i >= 0; i--) expB.push_back(8'((wdataV >> (8 * i)) & 32'hFF));
        expR = 32'h0;
        slaveQ.delete();
        for (int k = 0; k < b; k++) begin
            sb = 8'($urandom);
            slaveQ.push_back(sb);
            if (rwV && k >= 2) expR = (expR << 8) | {24'h0, sb};
        end
        logData.delete();
        logRead.delete();
        logStart.delete();
        stableErr = 0;

        req_i   = 1'b1;
        rw_i    = rwV;
        addr_i  = addrV;
        len_i   = lenV;
        wdata_i = wdataV;
        c0      = cycCnt;
        @(negedge CLK);
        req_i   = 1'b0;
        rw_i    = ~rwV;
        addr_i  = 13'($urandom);
        len_i   = 2'($urandom);
        wdata_i = $urandom;
        checkOutput({name, "/busy1"}, busy_o, 1);
        checkOutput({name, "/start1"}, chunk_start_o, 1);

        ackCyc  = -1;
        errSeen = 0;
        rdAtAck = 32'h0;
        for (int t = 0; t < 500; t++) begin
            if (err_o) errSeen++;
            if (ack_o) begin
                ackCyc  = cycCnt - c0;
                rdAtAck = rdata_o;
                break;
            end
            @(negedge CLK);
        end
        checkOutput({name, "/ackCycle"}, ackCyc, (engDelay + 1) * b + 1);
        checkOutput({name, "/noErr"}, errSeen, 0);
        checkOutput({name, "/rdata"}, rdAtAck, expR);
        checkOutput({name, "/byteCount"}, logData.size(), b);
        for (int i = 0; i < b && i < logData.size(); i++) begin
            checkOutput($sformatf("%s/byte%0d", name, i), logData[i], expB[i]);
            checkOutput($sformatf("%s/read%0d", name, i), logRead[i], (i >= 2) ? rwV : 1'b0);
            checkOutput($sformatf("%s/csbLow%0d", name, i), logStart[i] - c0, 1 + i * (engDelay + 1));
        end
        checkOutput({name, "/stable"}, stableErr, 0);
        @(negedge CLK);
        checkOutput({name, "/ackOneCycle"}, ack_o, 0);
        checkOutput({name, "/idleAfter"}, busy_o, 0);
        checkOutput({name, "/rdataHeld"}, rdata_o, expR);
    endtask

    initial begin
        int c0, errCyc, ackSeen, ackCnt;
        int ackCyc[3];
        logic [7:0] wsb;
        RST     = 1'b0;
        req_i   = 1'b0;
        rw_i    = 1'b0;
        addr_i  = 13'h0;
        len_i   = 2'h0;
        wdata_i = 32'h0;
        repeat (3) @(negedge CLK);
        checkOutput("reset/busy", busy_o, 0);
        checkOutput("reset/ack", ack_o, 0);
        checkOutput("reset/err", err_o, 0);
        checkOutput("reset/start", chunk_start_o, 0);
        checkOutput("reset/rdata", rdata_o, 0);
        checkOutput("reset/chunkData", chunk_data_o, 0);
        checkOutput("reset/chunkRead", chunk_read_o, 0);

        // Request raised together with reset release: accepted on the very next edge.
        RST = 1'b1;
        applyStimulus("wr005", 1'b0, 13'h005, 2'd0, 32'h0000_00A5);

        applyStimulus("rd0123", 1'b1, 13'h0123, 2'd1, 32'h0);
        @(negedge CLK);
        applyStimulus("wr1FFF", 1'b0, 13'h1FFF, 2'd3, 32'hDEAD_BEEF);

        for (int r = 0; r < 8; r++) begin
            applyStimulus($sformatf("rand%0d", r), 1'($urandom), 13'($urandom), 2'($urandom), $urandom);
        end

        // Finish arriving in exactly the expiry cycle must still complete normally.
        engDelay = WDT - 1;
        applyStimulus("finishWins", 1'b1, 13'h0AA, 2'd0, 32'h0);
        engDelay = spi_ctrl_pkg::BYTE_CYCLES - 1;

        engDelay = WDT;
        logData.delete();
        req_i   = 1'b1;
        rw_i    = 1'b0;
        addr_i  = 13'h010;
        len_i   = 2'd0;
        wdata_i = 32'h55;
        c0      = cycCnt;
        @(negedge CLK);
        req_i  = 1'b0;
        errCyc = -1;
        ackSeen = 0;
        for (int t = 0; t < 100; t++) begin
            if (ack_o) ackSeen++;
            if (err_o) begin
                errCyc = cycCnt - c0;
                break;
            end
            @(negedge CLK);
        end
        checkOutput("wdt/errCycle", errCyc, 1 + WDT);
        checkOutput("wdt/noAck", ackSeen, 0);
        @(negedge CLK);
        checkOutput("wdt/errPulse", err_o, 0);
        checkOutput("wdt/idle", busy_o, 0);
        repeat (3) @(negedge CLK);
        checkOutput("wdt/lateFinishIgnored", busy_o, 0);
        checkOutput("wdt/lateAck", ack_o, 0);
        checkOutput("wdt/bytes", logData.size(), 1);
        engDelay = spi_ctrl_pkg::BYTE_CYCLES - 1;

        // Request held high: transactions must chain with exactly one idle cycle between them.
        logData.delete();
        slaveQ.delete();
        req_i   = 1'b1;
        rw_i    = 1'b0;
        addr_i  = 13'h0AB;
        len_i   = 2'd1;
        wdata_i = $urandom;
        c0      = cycCnt;
        ackCnt  = 0;
        for (int t = 0; t < 600 && ackCnt < 3; t++) begin
            @(negedge CLK);
            if (ack_o) begin
                ackCyc[ackCnt] = cycCnt - c0;
                ackCnt++;
                if (ackCnt == 3) req_i = 1'b0;
            end
        end
        req_i = 1'b0;
        checkOutput("b2b/ackCount", ackCnt, 3);
        checkOutput("b2b/ack0", ackCyc[0], 18 * 4 + 1);
        checkOutput("b2b/ack1", ackCyc[1], 18 * 4 + 1 + (18 * 4 + 2));
        checkOutput("b2b/ack2", ackCyc[2], 18 * 4 + 1 + 2 * (18 * 4 + 2));
        checkOutput("b2b/starts", logData.size(), 12);
        @(negedge CLK);
        checkOutput("b2b/idle", busy_o, 0);

        // Reset in the middle of the third data byte of a four-byte read.
        logStart.delete();
        slaveQ.delete();
        for (int k = 0; k < 6; k++) begin
            wsb = 8'($urandom_range(1, 255));
            slaveQ.push_back(wsb);
        end
        req_i   = 1'b1;
        rw_i    = 1'b1;
        addr_i  = 13'h155;
        len_i   = 2'd3;
        wdata_i = 32'hCAFE_F00D;
        @(negedge CLK);
        req_i = 1'b0;
        for (int t = 0; t < 200 && logStart.size() < 5; t++) @(negedge CLK);
        checkOutput("rstMid/reachedByte3", (logStart.size() >= 5) ? 1 : 0, 1);
        repeat (3) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        checkOutput("rstMid/busy", busy_o, 0);
        checkOutput("rstMid/ack", ack_o, 0);
        checkOutput("rstMid/err", err_o, 0);
        checkOutput("rstMid/start", chunk_start_o, 0);
        checkOutput("rstMid/rdata", rdata_o, 0);
        checkOutput("rstMid/chunkData", chunk_data_o, 0);
        checkOutput("rstMid/chunkRead", chunk_read_o, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("rstMid/noAckAfter", ack_o, 0);
        checkOutput("rstMid/noErrAfter", err_o, 0);
        applyStimulus("afterReset", 1'b1, 13'h0F0, 2'd2, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
